div_seq8x4: RTL

Sequential restoring divider: 8-bit unsigned dividend by 4-bit unsigned divisor, producing an 8-bit quotient and a 4-bit remainder. It computes one quotient bit per clock under a start/done handshake. It is the inverse-operation companion to the team's 4-bit combinational multiplier in the arithmetic datapath library. It trades latency for area: a single 5-bit subtractor and shift registers, no array.

---
 rtl/div_seq8x4_if.sv | 14 +
 rtl/div_seq8x4.sv | 103 ++++++++++
 2 files changed

// File: rtl/div_seq8x4_if.sv
// rtl/div_seq8x4_if.sv - start/done handshake and operand/result bus for the sequential 8/4 divider
interface div_seq8x4_if;
    logic       start;
    logic [7:0] N;
    logic [3:0] D;
    logic [7:0] Q;
    logic [3:0] R;
    logic       busy;
    logic       done;
    logic       dbz;

    modport master (output start, N, D, input Q, R, busy, done, dbz);
    modport slave  (input start, N, D, output Q, R, busy, done, dbz);
endinterface

// File: rtl/div_seq8x4.sv
// rtl/div_seq8x4.sv - restoring divider, 8-bit dividend by 4-bit divisor, one quotient bit per clock
module div_seq8x4 (
    input  logic         clk,
    input  logic         rst,
    div_seq8x4_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [3:0] rem;
    logic [2:0] count;
    logic [7:0] q_reg;
    logic [3:0] r_reg;
    logic       dbz_reg;

    logic       accept;
    logic [4:0] trial;
    logic       ge;
    logic [3:0] rem_next;
    logic [7:0] dividend_next;

    // t - D always fits in 4 bits because t < 2*D, so the subtract can drop the carry
    always_comb begin
        accept        = ((state == IDLE) || (state == DONE)) && bus.start;
        trial         = {rem, dividend[7]};
        ge            = (trial >= {1'b0, divisor});
        rem_next      = ge ? (trial[3:0] - divisor) : trial[3:0];
        dividend_next = {dividend[6:0], ge};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next = (bus.D == 4'd0) ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (count == 3'd7) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dividend <= 8'd0;
            divisor  <= 4'd0;
            rem      <= 4'd0;
            count    <= 3'd0;
            q_reg    <= 8'd0;
            r_reg    <= 4'd0;
            dbz_reg  <= 1'b0;
        end else if (accept) begin
            if (bus.D != 4'd0) begin
                dividend <= bus.N;
                divisor  <= bus.D;
                rem      <= 4'd0;
                count    <= 3'd0;
                dbz_reg  <= 1'b0;
            end else begin
                q_reg    <= 8'hFF;
                r_reg    <= 4'h0;
                dbz_reg  <= 1'b1;
            end
        end else if (state == RUN) begin
            rem      <= rem_next;
            dividend <= dividend_next;
            count    <= count + 3'd1;
            // Results publish only on the final iteration so Q/R never show partial values
            if (count == 3'd7) begin
                q_reg <= dividend_next;
                r_reg <= rem_next;
            end
        end
    end

    assign bus.Q    = q_reg;
    assign bus.R    = r_reg;
    assign bus.dbz  = dbz_reg;
    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
endmodule
